// File: rtl/lognum_pkg.sv
// lognum_pkg
// Shared definitions for the log-domain number format used by the
// Mitchell-style approximate multiplier in the systolic-array PE.
//   LOG_I_W   : default operand width (two's complement)
//   LOG_F_W   : default fractional mantissa width
//   LOG_O_W   : characteristic width derived from LOG_I_W
//   log_num_t : {sign, zero, chr, frac} bundle at the default widths.
//               Blocks that are built with other widths declare a struct
//               with the same field order sized by their own parameters.
// The field is called "chr" because "char" is a SystemVerilog keyword.
package lognum_pkg;

    localparam int LOG_I_W = 16;
    localparam int LOG_F_W = 8;
    localparam int LOG_O_W = $clog2(LOG_I_W);

    typedef struct packed {
        logic               sign;
        logic               zero;
        logic [LOG_O_W-1:0] chr;
        logic [LOG_F_W-1:0] frac;
    } log_num_t;

endpackage

// File: rtl/lopd.sv
// lopd
// Leading-one position detector. Returns the index of the most significant
// set bit of d; an all-zero input returns 0 (callers flag zero separately).
// Parameters:
//   I_W : input width
// Ports:
//   d   : input  [I_W-1:0]      value to scan
//   pos : output [O_W-1:0]      index of the leading one
module lopd #(
    parameter  int I_W = 16,
    localparam int O_W = $clog2(I_W)
) (
    input  logic [I_W-1:0] d,
    output logic [O_W-1:0] pos
);

    // Scan from LSB upward so the highest set bit is the last one written.
    always_comb begin
        pos = '0;
        for (int i = 0; i < I_W; i++) begin
            if (d[i]) begin
                pos = O_W'(i);
            end
        end
    end

endmodule

// File: rtl/log_encoder_pipe.sv
// log_encoder_pipe
// Two-stage valid/ready pipeline that converts a two's-complement operand
// into the log-domain bundle {sign, zero, characteristic, fraction} consumed
// by the log-domain adder.
//   S1 : registers sign, zero flag and magnitude |i_d|.
//   S2 : leading-one detect (lopd), normalising shift, fraction extract.
// Optional build macro:
//   LOGENC_ROUND_EN : round the fraction to nearest (ties up) using the bit
//                     just below it; a carry out bumps the characteristic.
//                     Undefined: the fraction is truncated.
// Parameters:
//   I_W : operand width (>= 4), F_W : fraction width (>= 1)
// Ports:
//   i_clk, i_rstn      : clock (rising edge), async active-low reset
//   i_d, i_valid       : operand and its valid
//   o_ready            : operand accepted this cycle when i_valid is high
//   o_valid, i_ready   : output bundle valid / downstream accepts it
//   o_sign, o_zero     : operand negative / operand exactly zero
//   o_char             : leading-one position of |i_d|
//   o_frac             : bits below the leading one, MSB-aligned
module log_encoder_pipe
    import lognum_pkg::*;
#(
    parameter  int I_W = LOG_I_W,
    parameter  int F_W = LOG_F_W,
    localparam int O_W = $clog2(I_W)
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [I_W-1:0] i_d,
    input  logic           i_valid,
    output logic           o_ready,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_sign,
    output logic           o_zero,
    output logic [O_W-1:0] o_char,
    output logic [F_W-1:0] o_frac
);

    // Same layout as lognum_pkg::log_num_t, sized for this instance.
    typedef struct packed {
        logic           sign;
        logic           zero;
        logic [O_W-1:0] chr;
        logic [F_W-1:0] frac;
    } log_num_p_t;

    // The normaliser output is padded below with F_W+1 zeros so both the
    // fraction and the rounding bit exist even when F_W > I_W-1.
    localparam int EXT_W = I_W + F_W + 1;

    logic             s1_valid;
    logic             s1_sign;
    logic             s1_zero;
    logic [I_W-1:0]   s1_mag;
    logic             s2_valid;
    log_num_p_t       s2_q;
    log_num_p_t       s2_d;
    logic             s1_load;
    logic             s2_load;
    logic [I_W-1:0]   in_mag;
    logic [O_W-1:0]   lead;
    logic [O_W-1:0]   shamt;
    logic [I_W-1:0]   norm;
    logic [EXT_W-1:0] ext;
`ifdef LOGENC_ROUND_EN
    logic [F_W:0]     frac_rnd;
    logic [F_W:0]     frac_sum;
`endif

    // Each stage advances when it is empty or its successor is advancing,
    // so a full pipeline still moves one item per cycle.
    assign s2_load = !s2_valid || i_ready;
    assign s1_load = !s1_valid || s2_load;
    assign o_ready = s1_load;

    // Unsigned magnitude; the most negative value maps onto 2^(I_W-1).
    assign in_mag = i_d[I_W-1] ? (~i_d + I_W'(1)) : i_d;

    lopd #(
        .I_W (I_W)
    ) u_lopd (
        .d   (s1_mag),
        .pos (lead)
    );

    // Stage 2 datapath: shift the leading one to the MSB and take the bits
    // under it. A zero magnitude yields lead=0, norm=0 and hence frac=0.
    always_comb begin
        s2_d  = '0;
        shamt = O_W'(I_W - 1) - lead;
        norm  = s1_mag << shamt;
        ext   = {norm, {(F_W + 1){1'b0}}};
`ifdef LOGENC_ROUND_EN
        frac_rnd  = (F_W + 1)'(ext >> (EXT_W - 2 - F_W));
        frac_sum  = {1'b0, frac_rnd[F_W:1]} + {{F_W{1'b0}}, frac_rnd[0]};
        s2_d.frac = frac_sum[F_W-1:0];
        s2_d.chr  = frac_sum[F_W] ? (lead + O_W'(1)) : lead;
`else
        s2_d.frac = F_W'(ext >> (EXT_W - 1 - F_W));
        s2_d.chr  = lead;
`endif
        s2_d.sign = s1_sign & ~s1_zero;
        s2_d.zero = s1_zero;
    end

    // Stage 1 register: captures sign, zero flag and magnitude on accept.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mag   <= '0;
        end else if (s1_load) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign <= i_d[I_W-1];
                s1_zero <= (i_d == '0);
                s1_mag  <= in_mag;
            end
        end
    end

    // Stage 2 register: holds the output bundle until downstream takes it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign o_valid = s2_valid;
    assign o_sign  = s2_q.sign;
    assign o_zero  = s2_q.zero;
    assign o_char  = s2_q.chr;
    assign o_frac  = s2_q.frac;

endmodule

// File: tb/tb_log_encoder_pipe.sv
// tb_log_encoder_pipe
// Directed bench for log_encoder_pipe at I_W=16, F_W=8. Expected values are
// hand-computed constants for the directed vectors and a behavioural
// integer model for the streaming phases. Builds with or without
// LOGENC_ROUND_EN; rounding-dependent expectations follow the macro.
module tb_log_encoder_pipe;

    localparam int I_W = 16;
    localparam int F_W = 8;
    localparam int O_W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [I_W-1:0] operand;
    logic           src_valid;
    logic           sink_ready;
    logic           enc_ready;
    logic           enc_valid;
    logic           enc_sign;
    logic           enc_zero;
    logic [O_W-1:0] enc_char;
    logic [F_W-1:0] enc_frac;
    logic [13:0]    obs_bundle;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [13:0] exp_q[$];
    logic        held_valid;
    logic [13:0] held_bundle;

    always #5 clk = ~clk;

    assign obs_bundle = {enc_sign, enc_zero, enc_char, enc_frac};

    log_encoder_pipe #(
        .I_W (I_W),
        .F_W (F_W)
    ) dut (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_d     (operand),
        .i_valid (src_valid),
        .o_ready (enc_ready),
        .o_valid (enc_valid),
        .i_ready (sink_ready),
        .o_sign  (enc_sign),
        .o_zero  (enc_zero),
        .o_char  (enc_char),
        .o_frac  (enc_frac)
    );

    // Behavioural reference: integer log2 and scaled remainder.
    function automatic logic [13:0] ref_model(input logic [15:0] v);
        longint s;
        longint mag;
        longint rem;
        longint fr;
        int     c;
        logic   sg;
`ifdef LOGENC_ROUND_EN
        longint nb;
`endif
        s   = longint'($signed(v));
        sg  = (s < 0);
        mag = sg ? -s : s;
        if (mag == 0) begin
            return {1'b0, 1'b1, 4'd0, 8'd0};
        end
        c = 0;
        while ((mag >> (c + 1)) != 0) c++;
        rem = mag - (longint'(1) << c);
        fr  = (rem << F_W) >> c;
`ifdef LOGENC_ROUND_EN
        nb = ((rem << (F_W + 1)) >> c) & 1;
        if (nb == 1) fr = fr + 1;
        if (fr == (longint'(1) << F_W)) begin
            fr = 0;
            c  = c + 1;
        end
`endif
        return {sg, 1'b0, c[3:0], fr[7:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic vld, input logic rdy);
        operand    = v;
        src_valid  = vld;
        sink_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One item through an otherwise idle pipeline with the sink always ready.
    task automatic send_single(input logic [15:0] v, input string tag, input logic [13:0] exp);
        applyStimulus(v, 1'b1, 1'b1);
        #1;
        checkOutput({tag, " accept"}, 32'(enc_ready), 32'd1);
        tick();
        applyStimulus('0, 1'b0, 1'b1);
        #1;
        checkOutput({tag, " not early"}, 32'(enc_valid), 32'd0);
        tick();
        checkOutput({tag, " valid"}, 32'(enc_valid), 32'd1);
        checkOutput(tag, 32'(obs_bundle), 32'(exp));
    endtask

    // One streaming cycle with scoreboard, ready rule and hold checks.
    task automatic stream_cycle(input logic [15:0] v, input logic vld, input logic rdy,
                                output logic acc, output logic dlv);
        applyStimulus(v, vld, rdy);
        #1;
        if (held_valid) begin
            checkOutput("hold valid", 32'(enc_valid), 32'd1);
            checkOutput("hold bundle", 32'(obs_bundle), 32'(held_bundle));
        end
        checkOutput("ready rule", 32'(enc_ready), 32'(!(exp_q.size() == 2 && !rdy)));
        acc = vld && enc_ready;
        dlv = enc_valid && rdy;
        if (dlv) begin
            if (exp_q.size() == 0) checkOutput("spurious output", 32'(exp_q.size()), 32'd1);
            else checkOutput("stream data", 32'(obs_bundle), 32'(exp_q.pop_front()));
        end
        if (acc) exp_q.push_back(ref_model(v));
        held_valid  = enc_valid && !rdy;
        held_bundle = obs_bundle;
        tick();
    endtask

    task automatic drain(input string tag);
        logic acc;
        logic dlv;
        int   cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            stream_cycle('0, 1'b0, 1'b1, acc, dlv);
            cyc++;
        end
        checkOutput({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        acc;
        logic        dlv;
        logic [15:0] next;
        logic [31:0] r;
        int          cyc;
        int          delivered;
        int          accepted;
        int          ready_low;
        int          seen;

        // Reset state
        rst_n = 1'b0;
        held_valid  = 1'b0;
        held_bundle = '0;
        applyStimulus('0, 1'b0, 1'b1);
        #2;
        checkOutput("reset valid", 32'(enc_valid), 32'd0);
        checkOutput("reset bundle", 32'(obs_bundle), 32'd0);
        checkOutput("reset ready", 32'(enc_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors, hand-computed
        send_single(16'h0058, "d 0x0058", {1'b0, 1'b0, 4'd6, 8'h60});
        send_single(16'hFFA8, "d -88", {1'b1, 1'b0, 4'd6, 8'h60});
        send_single(16'hFFFF, "d 0xFFFF", {1'b1, 1'b0, 4'd0, 8'h00});
        send_single(16'h8000, "d 0x8000", {1'b1, 1'b0, 4'd15, 8'h00});
        send_single(16'h0000, "d 0x0000", {1'b0, 1'b1, 4'd0, 8'h00});
        send_single(16'h0003, "d 0x0003", {1'b0, 1'b0, 4'd1, 8'h80});
        send_single(16'h01FF, "d 0x01FF", {1'b0, 1'b0, 4'd8, 8'hFF});
`ifdef LOGENC_ROUND_EN
        send_single(16'h03FF, "d 0x03FF", {1'b0, 1'b0, 4'd10, 8'h00});
        send_single(16'h7FFF, "d 0x7FFF", {1'b0, 1'b0, 4'd15, 8'h00});
        send_single(16'h0301, "d 0x0301", {1'b0, 1'b0, 4'd9, 8'h81});
`else
        send_single(16'h03FF, "d 0x03FF", {1'b0, 1'b0, 4'd9, 8'hFF});
        send_single(16'h7FFF, "d 0x7FFF", {1'b0, 1'b0, 4'd14, 8'hFF});
        send_single(16'h0301, "d 0x0301", {1'b0, 1'b0, 4'd9, 8'h80});
`endif
        tick();

        // Reset with two items in flight
        applyStimulus(16'h0058, 1'b1, 1'b0);
        tick();
        applyStimulus(16'h0003, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        #1;
        checkOutput("full valid", 32'(enc_valid), 32'd1);
        checkOutput("full ready", 32'(enc_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset valid", 32'(enc_valid), 32'd0);
        checkOutput("midreset bundle", 32'(obs_bundle), 32'd0);
        checkOutput("midreset ready", 32'(enc_ready), 32'd1);
        applyStimulus('0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (enc_valid) seen++;
        end
        checkOutput("no stale after reset", 32'(seen), 32'd0);

        // Backpressure stream 1..16, sink stalled for 5 cycles
        exp_q.delete();
        held_valid = 1'b0;
        next = 16'd1;
        cyc = 0;
        delivered = 0;
        ready_low = 0;
        while (delivered < 16 && cyc < 200) begin
            stream_cycle(next, next <= 16'd16, !(cyc >= 4 && cyc < 9), acc, dlv);
            if (acc) next++;
            if (dlv) delivered++;
            if (!enc_ready && next <= 16'd16) ready_low++;
            cyc++;
        end
        checkOutput("bp delivered", 32'(delivered), 32'd16);
        checkOutput("bp ready low cycles", 32'(ready_low), 32'd5);
        drain("bp");

        // Random handshakes, 10000 operands
        held_valid = 1'b0;
        accepted = 0;
        delivered = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            r = $urandom();
            case (r[31:29])
                3'd0:    next = 16'h8000;
                3'd1:    next = 16'h0000;
                3'd2:    next = 16'h7FFF;
                default: next = r[15:0];
            endcase
            stream_cycle(next, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc, dlv);
            if (acc) accepted++;
            if (dlv) delivered++;
            cyc++;
        end
        checkOutput("random accepted", 32'(accepted), 32'd10000);
        drain("random");

        // Full throughput with both sides held high
        held_valid = 1'b0;
        delivered = 0;
        for (int i = 0; i < 22; i++) begin
            stream_cycle(16'(i * 37 + 5), 1'b1, 1'b1, acc, dlv);
            if (dlv) delivered++;
        end
        checkOutput("throughput", 32'(delivered), 32'd20);
        drain("throughput");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
